// File: rtl/msu_data_buffer.sv
// 16 KiB x 8 simple dual-port buffer between the MCU write path and the MSU-1 data window.
// Zero-fills itself after every reset so no stale bytes are ever read back.
module msu_data_buffer #(
  parameter int unsigned ADDR_W = 14,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clkin,
  input  logic              rst_n,
  input  logic              wren,
  input  logic [ADDR_W-1:0] wraddress,
  input  logic [DATA_W-1:0] data,
  input  logic [ADDR_W-1:0] rdaddress,
  output logic [DATA_W-1:0] q,
  output logic              init_busy
);

  localparam int unsigned DEPTH = 32'd1 << ADDR_W;

  typedef enum logic {
    S_INIT = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] ptr;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              mem_we_c;
  logic [ADDR_W-1:0] mem_wa_c;
  logic [DATA_W-1:0] mem_wd_c;

  // Write-port mux: the clear pointer owns the port during fill, host writes are dropped.
  always_comb begin
    mem_we_c = 1'b0;
    mem_wa_c = wraddress;
    mem_wd_c = data;
    if (rst_n) begin
      if (state == S_INIT) begin
        mem_we_c = 1'b1;
        mem_wa_c = ptr;
        mem_wd_c = '0;
      end else begin
        mem_we_c = wren;
      end
    end
  end

  always_ff @(posedge clkin) begin
    if (mem_we_c) begin
      mem[mem_wa_c] <= mem_wd_c;
    end
  end

  // Registered read; NBA ordering gives read-before-write on an address collision.
  always_ff @(posedge clkin) begin
    if (!rst_n) begin
      q <= '0;
    end else if (state == S_INIT) begin
      q <= '0;
    end else begin
      q <= mem[rdaddress];
    end
  end

  // Fill sequencer: init_busy falls on the same edge that clears the last address.
  always_ff @(posedge clkin) begin
    if (!rst_n) begin
      state     <= S_INIT;
      ptr       <= '0;
      init_busy <= 1'b1;
    end else begin
      case (state)
        S_INIT: begin
          ptr <= ptr + ADDR_W'(1);
          if (ptr == {ADDR_W{1'b1}}) begin
            state     <= S_RUN;
            init_busy <= 1'b0;
          end
        end
        S_RUN: begin
          state <= S_RUN;
        end
        default: begin
          state <= S_INIT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_msu_data_buffer.sv
// Scoreboard bench for msu_data_buffer: a reference byte array predicts every q,
// expected bytes are queued when an address is presented and popped one cycle later.
`timescale 1ns/1ps
module tb_msu_data_buffer;

  localparam int unsigned ADDR_W = 14;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned DEPTH  = 32'd1 << ADDR_W;

  logic              clkin = 1'b0;
  logic              rst_n = 1'b0;
  logic              wren = 1'b0;
  logic [ADDR_W-1:0] wraddress = '0;
  logic [DATA_W-1:0] data = '0;
  logic [ADDR_W-1:0] rdaddress = '0;
  logic [DATA_W-1:0] q;
  logic              init_busy;

  logic [DATA_W-1:0] model [DEPTH];
  logic [DATA_W-1:0] exp_q [$];
  int checks = 0;
  int errors = 0;

  msu_data_buffer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clkin(clkin), .rst_n(rst_n), .wren(wren), .wraddress(wraddress),
    .data(data), .rdaddress(rdaddress), .q(q), .init_busy(init_busy)
  );

  always #5 clkin = ~clkin;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clkin);
    #1;
  endtask

  task automatic host_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    wren = 1'b1; wraddress = a; data = d;
    tick();
    wren = 1'b0;
    model[a] = d;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; wren = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (q !== 8'h00 || init_busy !== 1'b1) begin
        errors++;
        $display("FAIL reset_state: q=%h init_busy=%b, required q=00 init_busy=1", q, init_busy);
      end
    end
    rst_n = 1'b1;
  endtask

  // Runs the fill from an rst_n release, optionally hammering a host write the whole time.
  task automatic test_fill(input bit host_hammer);
    int cycles = 0;
    if (host_hammer) begin
      wren = 1'b1; wraddress = 14'h0010; data = 8'hFF;
    end
    for (int n = 1; n <= 20000; n++) begin
      rdaddress = ADDR_W'($urandom);
      tick();
      if (!init_busy) begin
        cycles = n;
        break;
      end
      checks++;
      if (q !== 8'h00) begin
        errors++;
        $display("FAIL q_during_init: cycle %0d q=%h, required 00", n, q);
      end
    end
    wren = 1'b0;
    checks++;
    if (cycles != 16384) begin
      errors++;
      $display("FAIL fill_length: init_busy high for %0d cycles, required 16384", cycles);
    end
    for (int i = 0; i < int'(DEPTH); i++) model[i] = 8'h00;
  endtask

  task automatic test_read_all();
    logic [DATA_W-1:0] e;
    for (int i = 0; i < int'(DEPTH); i++) begin
      rdaddress = ADDR_W'(i);
      exp_q.push_back(model[i]);
      tick();
      e = exp_q.pop_front();
      checks++;
      if (q !== e) begin
        errors++;
        $display("FAIL read_all: addr %h q=%h, required %h", i, q, e);
      end
    end
  endtask

  task automatic test_write_readback();
    logic [ADDR_W-1:0] addrs [3];
    logic [DATA_W-1:0] e;
    addrs[0] = 14'h0000; addrs[1] = 14'h3FFF; addrs[2] = 14'h1234;
    host_write(addrs[0], 8'hA5);
    host_write(addrs[1], 8'h5A);
    host_write(addrs[2], 8'h3C);
    for (int i = 0; i < 3; i++) begin
      rdaddress = addrs[i];
      exp_q.push_back(model[addrs[i]]);
      tick();
      e = exp_q.pop_front();
      checks++;
      if (q !== e) begin
        errors++;
        $display("FAIL write_readback: addr %h q=%h, required %h", addrs[i], q, e);
      end
    end
  endtask

  task automatic test_read_during_write();
    logic [DATA_W-1:0] e;
    host_write(14'h0100, 8'h11);
    wren = 1'b1; wraddress = 14'h0100; data = 8'h22; rdaddress = 14'h0100;
    exp_q.push_back(model[14'h0100]);
    tick();
    wren = 1'b0;
    model[14'h0100] = 8'h22;
    e = exp_q.pop_front();
    checks++;
    if (q !== e) begin
      errors++;
      $display("FAIL rdw_old_data: q=%h, required %h", q, e);
    end
    exp_q.push_back(model[14'h0100]);
    tick();
    e = exp_q.pop_front();
    checks++;
    if (q !== e) begin
      errors++;
      $display("FAIL rdw_new_data: q=%h, required %h", q, e);
    end
  endtask

  task automatic test_stream_wrap();
    logic [DATA_W-1:0] e;
    logic [DATA_W-1:0] prev;
    for (int i = 0; i < 256; i++) host_write(14'h3F80 + ADDR_W'(i), DATA_W'(i));
    rdaddress = 14'h3F80;
    tick();
    prev = q;
    for (int i = 0; i < 256; i++) begin
      rdaddress = 14'h3F80 + ADDR_W'(i);
      exp_q.push_back(model[14'h3F80 + ADDR_W'(i)]);
      checks++;
      if (i > 0 && q !== prev) begin
        errors++;
        $display("FAIL stream_lag: before edge %0d q=%h, required held %h", i, q, prev);
      end
      tick();
      e = exp_q.pop_front();
      checks++;
      if (q !== e) begin
        errors++;
        $display("FAIL stream_data: addr %h q=%h, required %h", rdaddress, q, e);
      end
      prev = e;
    end
  endtask

  task automatic test_init_write_dropped();
    logic [DATA_W-1:0] e;
    rdaddress = 14'h0010;
    exp_q.push_back(8'h00);
    tick();
    e = exp_q.pop_front();
    checks++;
    if (q !== e) begin
      errors++;
      $display("FAIL init_write_dropped: addr 0010 q=%h, required %h", q, e);
    end
  endtask

  task automatic test_reset_mid_run();
    for (int i = 0; i < 256; i++) host_write(14'h2000 + ADDR_W'(i), 8'h77);
    rdaddress = 14'h2000;
    tick();
    checks++;
    if (q !== 8'h77) begin
      errors++;
      $display("FAIL pre_reset_fill: q=%h, required 77", q);
    end
    rst_n = 1'b0;
    tick();
    checks++;
    if (q !== 8'h00 || init_busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_run_reset: q=%h init_busy=%b, required q=00 init_busy=1", q, init_busy);
    end
    rst_n = 1'b1;
    test_fill(1'b0);
    test_read_all();
  endtask

  initial begin
    test_reset();
    test_fill(1'b1);
    test_init_write_dropped();
    test_read_all();
    test_write_readback();
    test_read_during_write();
    test_stream_wrap();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
